// File: rtl/bit_serial_adder.sv
// bit_serial_adder: WIDTH-bit adder built from a single full-adder slice and a
// registered carry. Operands are consumed LSB-first, one bit per clock, under a
// start/busy/done handshake.
//
// Optional feature: define BIT_SERIAL_ADDER_OVERFLOW_EN to add an 'overflow'
// output carrying the signed two's-complement overflow of the result.
module bit_serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    // Count value while the MSB is being processed.
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_out_q;

    logic             load;
    logic             shifting;
    logic             last_bit;
    logic             s_bit;
    logic             c_next;

    // A new add is accepted only when the slice is free (IDLE or the DONE cycle).
    assign load     = start && ((state_q == StIdle) || (state_q == StDone));
    assign shifting = (state_q == StShift);
    assign last_bit = shifting && (count_q == LAST);

    // Full-adder bit slice on the current LSBs and the registered carry.
    always_comb begin
        s_bit  = a_q[0] ^ b_q[0] ^ carry_q;
        c_next = (a_q[0] & b_q[0]) | (b_q[0] & carry_q) | (a_q[0] & carry_q);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (count_q == LAST) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // Back-to-back request skips IDLE entirely.
                state_d = start ? StShift : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StShift: busy = 1'b1;
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    // Operand shift registers, running carry and bit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
        end else if (load) begin
            a_q     <= input1;
            b_q     <= input2;
            carry_q <= carry_in;
            count_q <= '0;
        end else if (shifting) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            carry_q <= c_next;
            count_q <= count_q + CW'(1);
        end
    end

    // Result register: sum bits enter at the MSB and walk down to their place;
    // carry_out is captured with the MSB so it stays put with sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q       <= '0;
            carry_out_q <= 1'b0;
        end else if (load) begin
            sum_q       <= '0;
            carry_out_q <= 1'b0;
        end else if (shifting) begin
            sum_q <= {s_bit, sum_q[WIDTH-1:1]};
            if (last_bit) begin
                carry_out_q <= c_next;
            end
        end
    end

    assign sum       = sum_q;
    assign carry_out = carry_out_q;

`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
    logic overflow_q;

    // Signed overflow: carry into the MSB (carry_q) differs from carry out of it.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (load) begin
            overflow_q <= 1'b0;
        end else if (last_bit) begin
            overflow_q <= carry_q ^ c_next;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: directed cases at WIDTH=8 plus a
// shuffled exhaustive sweep at WIDTH=4, checked against plain-arithmetic results.
module tb_bit_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] in1_8, in2_8, sum8;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] in1_4, in2_4, sum4;
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
    logic       ovf8, ovf4;
`endif

    bit_serial_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .reset     (reset),
        .start     (start8),
        .input1    (in1_8),
        .input2    (in2_8),
        .carry_in  (cin8),
        .busy      (busy8),
        .done      (done8),
        .sum       (sum8),
        .carry_out (cout8)
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
        ,
        .overflow  (ovf8)
`endif
    );

    bit_serial_adder #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .start     (start4),
        .input1    (in1_4),
        .input2    (in2_4),
        .carry_in  (cin4),
        .busy      (busy4),
        .done      (done4),
        .sum       (sum4),
        .carry_out (cout4)
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
        ,
        .overflow  (ovf4)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned (w+1)-bit sum and signed overflow from operand/result signs.
    function automatic logic [32:0] ref_add(input int w, input int unsigned a,
                                            input int unsigned b, input bit cin);
        longint unsigned mask, t;
        mask = (64'd1 << w) - 1;
        t    = (a & mask) + (b & mask) + cin;
        return t[32:0] & ((33'd1 << (w + 1)) - 1);
    endfunction

    function automatic bit ref_ovf(input int w, input int unsigned a, input int unsigned b,
                                   input bit cin);
        logic [32:0] r;
        bit sa, sb, sr;
        r  = ref_add(w, a, b, cin);
        sa = a[w-1];
        sb = b[w-1];
        sr = r[w-1];
        return (sa == sb) && (sr != sa);
    endfunction

    task automatic drive(input int w, input bit s, input int unsigned a, input int unsigned b,
                         input bit cin);
        if (w == 8) begin
            start8 = s; in1_8 = a[7:0]; in2_8 = b[7:0]; cin8 = cin;
        end else begin
            start4 = s; in1_4 = a[3:0]; in2_4 = b[3:0]; cin4 = cin;
        end
    endtask

    function automatic bit obs_done(input int w);
        return (w == 8) ? done8 : done4;
    endfunction
    function automatic bit obs_busy(input int w);
        return (w == 8) ? busy8 : busy4;
    endfunction
    function automatic logic [32:0] obs_result(input int w);
        return (w == 8) ? {24'd0, cout8, sum8} : {28'd0, cout4, sum4};
    endfunction
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
    function automatic bit obs_ovf(input int w);
        return (w == 8) ? ovf8 : ovf4;
    endfunction
`endif

    // One add: pulse start for one edge, optionally pulse a spurious start with
    // other operands at SHIFT cycle glitch+1, then wait (bounded) for done.
    // Returns sitting 1ns after the edge that raised done.
    task automatic run_add(input int w, input int unsigned a, input int unsigned b,
                           input bit cin, input int glitch, input string tag);
        int cycles, nbusy;
        @(posedge clk); #1;
        drive(w, 1'b1, a, b, cin);
        @(posedge clk); #1;
        drive(w, 1'b0, a, b, cin);
        cycles = 0;
        nbusy  = 0;
        while (!obs_done(w) && cycles < 4 * w + 8) begin
            if (obs_busy(w)) nbusy++;
            if (cycles == glitch) drive(w, 1'b1, ~a, ~b, ~cin);
            else if (cycles == glitch + 1) drive(w, 1'b0, a, b, cin);
            @(posedge clk); #1;
            cycles++;
        end
        check({tag, ".latency"}, 64'(cycles), 64'(w));
        check({tag, ".busy_cycles"}, 64'(nbusy), 64'(w));
        check({tag, ".result"}, 64'(obs_result(w)), 64'(ref_add(w, a, b, cin)));
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
        check({tag, ".overflow"}, 64'(obs_ovf(w)), 64'(ref_ovf(w, a, b, cin)));
`endif
    endtask

    int order[512];

    initial begin
        int cycles;
        reset = 1'b1;
        drive(8, 1'b0, 0, 0, 1'b0);
        drive(4, 1'b0, 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset.busy8", 64'(busy8), 64'd0);
        check("reset.done8", 64'(done8), 64'd0);
        check("reset.result8", 64'(obs_result(8)), 64'd0);
        check("reset.busy4", 64'(busy4), 64'd0);
        check("reset.result4", 64'(obs_result(4)), 64'd0);
        reset = 1'b0;

        // Basic add, then done must be a single pulse with the result held.
        run_add(8, 32'h5A, 32'h33, 1'b0, -1, "t1");
        check("t1.sum_const", 64'(sum8), 64'h8D);
        @(posedge clk); #1;
        check("t1.done_pulse", 64'(done8), 64'd0);
        check("t1.idle_busy", 64'(busy8), 64'd0);
        check("t1.held", 64'(obs_result(8)), 64'h08D);

        run_add(8, 32'hFF, 32'h01, 1'b0, -1, "t2a");
        check("t2a.const", 64'(obs_result(8)), 64'h100);
        run_add(8, 32'h7F, 32'h00, 1'b1, -1, "t2b");
        check("t2b.const", 64'(obs_result(8)), 64'h080);

        // Spurious start in SHIFT cycle 3 must be ignored.
        run_add(8, 32'h5A, 32'h33, 1'b0, 2, "t3");

        // Reset in SHIFT cycle 4 aborts the add.
        @(posedge clk); #1;
        drive(8, 1'b1, 32'hC3, 32'h5E, 1'b1);
        @(posedge clk); #1;
        drive(8, 1'b0, 32'hC3, 32'h5E, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t4.busy", 64'(busy8), 64'd0);
        check("t4.done", 64'(done8), 64'd0);
        check("t4.result", 64'(obs_result(8)), 64'd0);
        cycles = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8 || busy8) cycles++;
        end
        check("t4.stays_idle", 64'(cycles), 64'd0);
        run_add(8, 32'hC3, 32'h5E, 1'b1, -1, "t4.fresh");

        // Back-to-back start during DONE: second done exactly WIDTH+1 cycles later.
        run_add(8, 32'h5A, 32'h33, 1'b0, -1, "t5a");
        drive(8, 1'b1, 32'h10, 32'h20, 1'b0);
        @(posedge clk); #1;
        drive(8, 1'b0, 32'h10, 32'h20, 1'b0);
        check("t5.no_gap", 64'(busy8), 64'd1);
        cycles = 1;
        while (!done8 && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("t5.spacing", 64'(cycles), 64'd9);
        check("t5.result", 64'(obs_result(8)), 64'h030);

        // Random 8-bit adds.
        for (int i = 0; i < 30; i++) begin
            run_add(8, $urandom_range(255, 0), $urandom_range(255, 0),
                    1'($urandom_range(1, 0)), -1, "rnd8");
        end

        // WIDTH=4: every operand/carry combination, in shuffled order.
        for (int i = 0; i < 512; i++) order[i] = i;
        for (int i = 511; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(i, 0));
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < 512; i++) begin
            int unsigned v;
            v = order[i];
            run_add(4, v & 32'hF, (v >> 4) & 32'hF, v[8], -1, "sweep4");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
